// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset controller: FSM states,
// ALU control codes, instruction field codes and the condition evaluator.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

  // nzcv packed as {N,Z,C,V}
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: cond_eval = z;
      COND_NE: cond_eval = ~z;
      COND_CS: cond_eval = c;
      COND_CC: cond_eval = ~c;
      COND_MI: cond_eval = n;
      COND_PL: cond_eval = ~n;
      COND_VS: cond_eval = v;
      COND_VC: cond_eval = ~v;
      COND_HI: cond_eval = c & ~z;
      COND_LS: cond_eval = ~c | z;
      COND_GE: cond_eval = ~(n ^ v);
      COND_LT: cond_eval = n ^ v;
      COND_GT: cond_eval = ~z & ~(n ^ v);
      COND_LE: cond_eval = z | (n ^ v);
      COND_AL: cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_cond_logic.sv
// Condition unit: NZCV flag register, per-instruction condition latch and
// gated flag update from the ALU.
module mc_cond_logic
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       cex_load,
  output logic       cex,
  output logic [3:0] flags
);

  logic [3:0] flags_q, flags_d;
  logic       cex_q, cex_d;

  always_comb begin
    flags_d = flags_q;
    if (cex_q && flag_w[1]) flags_d[3:2] = alu_flags[3:2];
    if (cex_q && flag_w[0]) flags_d[1:0] = alu_flags[1:0];
    // condition is frozen at DECODE so later states of the instruction agree
    cex_d = cex_load ? cond_eval(cond, flags_q) : cex_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
      cex_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      cex_q   <= cex_d;
    end
  end

  assign cex   = cex_q;
  assign flags = flags_q;

endmodule

// File: rtl/mc_controller_ws.sv
// Multicycle ARM-subset controller: main FSM with memory wait states, ALU
// decoder and conditional write gating for the datapath.
module mc_controller_ws
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 0,
  parameter bit BL_EN   = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:12] Instr,
  input  logic [3:0]   ALUFlags,
  output logic         PCWrite,
  output logic         MemWrite,
  output logic         RegWrite,
  output logic         IRWrite,
  output logic         AdrSrc,
  output logic         LinkWrite,
  output logic [1:0]   RegSrc,
  output logic [1:0]   ALUSrcA,
  output logic [1:0]   ALUSrcB,
  output logic [1:0]   ResultSrc,
  output logic [1:0]   ImmSrc,
  output logic [1:0]   ALUControl,
  output logic [3:0]   State
);

  localparam int WW = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

  state_e          state_q, state_d, dec_st;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic            mem_st, acc_done;
  logic            next_pc, irw, memw, regw, branch, link, alu_op, no_write;
  logic [1:0]      flag_w;
  logic            cex;
  logic [3:0]      flags;

  wire [1:0] op  = Instr[27:26];
  wire       imm = Instr[25];
  wire [3:0] cmd = Instr[24:21];
  wire       s_l = Instr[20];

  assign mem_st   = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  assign acc_done = !mem_st || (wcnt_q == WW'(MEM_LAT));

  always_comb begin
    wcnt_d  = acc_done ? '0 : wcnt_q + WW'(1);
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (acc_done) state_d = S_DECODE;
      S_DECODE:
        case (op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = imm ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      S_MEMADR:   state_d = s_l ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (acc_done) state_d = S_MEMWB;
      S_MEMWRITE: if (acc_done) state_d = S_FETCH;
      S_EXECUTER, S_EXECUTEI: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // while in reset the muxes present FETCH settings
  assign dec_st = reset ? S_FETCH : state_q;

  always_comb begin
    next_pc = 1'b0; irw = 1'b0; memw = 1'b0; regw = 1'b0;
    branch = 1'b0; link = 1'b0; alu_op = 1'b0;
    AdrSrc = 1'b0; ALUSrcA = 2'b00; ALUSrcB = 2'b00; ResultSrc = 2'b00;
    case (dec_st)
      S_FETCH: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        irw = acc_done; next_pc = acc_done;
      end
      S_DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
      S_MEMADR:   ALUSrcB = 2'b01;
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWRITE: begin AdrSrc = 1'b1; memw = 1'b1; end
      S_MEMWB:    begin ResultSrc = 2'b01; regw = 1'b1; end
      S_EXECUTER: alu_op = 1'b1;
      S_EXECUTEI: begin alu_op = 1'b1; ALUSrcB = 2'b01; end
      S_ALUWB:    regw = 1'b1;
      S_BRANCH: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01; ResultSrc = 2'b10; branch = 1'b1;
        if (BL_EN && cmd[3]) begin regw = 1'b1; link = 1'b1; end
      end
      default: ;
    endcase
  end

  always_comb begin
    ALUControl = ALU_ADD;
    flag_w     = 2'b00;
    if (alu_op) begin
      case (cmd)
        CMD_ADD:          ALUControl = ALU_ADD;
        CMD_SUB, CMD_CMP: ALUControl = ALU_SUB;
        CMD_AND:          ALUControl = ALU_AND;
        CMD_ORR:          ALUControl = ALU_ORR;
        default:          ALUControl = ALU_ADD;
      endcase
      flag_w[1] = s_l;
      flag_w[0] = s_l && (cmd == CMD_ADD || cmd == CMD_SUB || cmd == CMD_CMP);
    end
  end

  // CMP never writes its destination, whichever state asks for a write
  assign no_write = (op == OP_DP) && (cmd == CMD_CMP);

  mc_cond_logic u_cond (
    .clk       (clk),
    .reset     (reset),
    .cond      (Instr[31:28]),
    .alu_flags (ALUFlags),
    .flag_w    (flag_w),
    .cex_load  (state_q == S_DECODE),
    .cex       (cex),
    .flags     (flags)
  );

  assign PCWrite   = !reset && (next_pc || (branch && cex));
  assign RegWrite  = !reset && regw && cex && !no_write;
  assign MemWrite  = !reset && memw && cex;
  assign IRWrite   = !reset && irw;
  assign LinkWrite = !reset && link;
  assign ImmSrc    = op;
  assign RegSrc    = {(op == OP_MEM) && !s_l, op == OP_BR};
  assign State     = state_q;

endmodule
